// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture: per-channel synchroniser, glitch filter,
// registered edge strobes and sticky pending/overflow flags (write-1-to-clear)
// aggregated into a single interrupt request.
module edge_event_capture #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                  arst_ni,
  input  logic                  clk_i,
  input  logic [NUM_CH-1:0]     d_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clear_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     posedge_o,
  output logic [NUM_CH-1:0]     negedge_o,
  output logic [NUM_CH-1:0]     pending_o,
  output logic [NUM_CH-1:0]     overflow_o,
  output logic                  irq_o
);

  localparam int unsigned     CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] synced;
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [NUM_CH-1:0] ev;

  // Synchroniser shift chain; the last stage feeds the filter.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {NUM_CH{RESET_LEVEL}};
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Glitch filter: accept a new level only after it persists FILTER_CYCLES
  // cycles; strobes are registered alongside the level update.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      level_o   <= {NUM_CH{RESET_LEVEL}};
      posedge_o <= '0;
      negedge_o <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        posedge_o[ch] <= 1'b0;
        negedge_o[ch] <= 1'b0;
        if (synced[ch] == level_o[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          level_o[ch]   <= synced[ch];
          cnt_q[ch]     <= '0;
          posedge_o[ch] <= synced[ch];
          negedge_o[ch] <= ~synced[ch];
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Enabled event per channel, qualified by the current mode select.
  always_comb begin
    ev = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      ev[ch] = (posedge_o[ch] & mode_i[2*ch]) | (negedge_o[ch] & mode_i[2*ch+1]);
    end
  end

  // Sticky capture; a new event wins over a coincident clear so none is lost.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pending_o  <= '0;
      overflow_o <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (ev[ch]) begin
          pending_o[ch] <= 1'b1;
          if (clear_i[ch]) begin
            overflow_o[ch] <= 1'b0;
          end else if (pending_o[ch]) begin
            overflow_o[ch] <= 1'b1;
          end
        end else if (clear_i[ch]) begin
          pending_o[ch]  <= 1'b0;
          overflow_o[ch] <= 1'b0;
        end
      end
    end
  end

  assign irq_o = |pending_o;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture (4 channels, 2 sync stages, filter 3)
// plus a single-channel idle-high instance sharing clock and reset.
module tb_edge_event_capture;

  logic       clk = 1'b0;
  logic       arst_ni;
  logic [3:0] d, clear;
  logic [7:0] mode;
  logic [3:0] level, pos, neg, pend, ovf;
  logic       irq;

  logic       d1;
  logic [1:0] mode1;
  logic       clear1;
  logic       level1, pos1, neg1, pend1, ovf1, irq1;

  int unsigned checks = 0;
  int unsigned passed = 0;

  edge_event_capture #(
    .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_LEVEL(1'b0)
  ) dut (
    .arst_ni(arst_ni), .clk_i(clk), .d_i(d), .mode_i(mode), .clear_i(clear),
    .level_o(level), .posedge_o(pos), .negedge_o(neg),
    .pending_o(pend), .overflow_o(ovf), .irq_o(irq)
  );

  edge_event_capture #(
    .NUM_CH(1), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_LEVEL(1'b1)
  ) dut_hi (
    .arst_ni(arst_ni), .clk_i(clk), .d_i(d1), .mode_i(mode1), .clear_i(clear1),
    .level_o(level1), .posedge_o(pos1), .negedge_o(neg1),
    .pending_o(pend1), .overflow_o(ovf1), .irq_o(irq1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] pnd;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic [3:0] dv, clr, lvl, pv, nv, pnd, ov);
    vec_t v;
    v.d = dv; v.clr = clr; v.lvl = lvl; v.pos = pv; v.neg = nv; v.pnd = pnd; v.ovf = ov;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_hi(input string tag);
    check({tag, " hi level"}, level1, 1);
    check({tag, " hi posedge"}, pos1, 0);
    check({tag, " hi negedge"}, neg1, 0);
    check({tag, " hi pending"}, pend1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Row r: inputs applied before edge r, outputs checked just after it.
    // Modes: ch0 rise, ch1 both, ch2 fall, ch3 both.
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(2, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(2, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(1, 4'b0101, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 4'b0001, 4'b0000);
    add(4, 4'b0001, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 4'b0000);
    add(2, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0000);
    add(4, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0000);
    add(1, 4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b0000, 4'b0101, 4'b0000);
    add(4, 4'b0001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1101, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b1101, 4'b0000);
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1101, 4'b1000);
    add(4, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1101, 4'b1000);
    add(1, 4'b1001, 4'b0000, 4'b1001, 4'b1000, 4'b0000, 4'b1101, 4'b1000);
    add(1, 4'b1001, 4'b1000, 4'b1001, 4'b0000, 4'b0000, 4'b1101, 4'b0000);
    add(1, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1101, 4'b0000);
    add(1, 4'b1001, 4'b1101, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b1001, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    arst_ni = 1'b0;
    d = '0; clear = '0; mode = 8'b11_10_11_01;
    d1 = 1'b1; clear1 = 1'b0; mode1 = 2'b11;
    @(posedge clk); @(posedge clk); #1;
    check("reset level", level, 0);
    check("reset pending", pend, 0);
    check("reset overflow", ovf, 0);
    check("reset irq", irq, 0);
    check("reset hi level", level1, 1);
    @(negedge clk); arst_ni = 1'b1;

    foreach (tbl[r]) begin
      @(negedge clk);
      d = tbl[r].d; clear = tbl[r].clr;
      @(posedge clk); #1;
      check($sformatf("row%0d level", r), level, tbl[r].lvl);
      check($sformatf("row%0d posedge", r), pos, tbl[r].pos);
      check($sformatf("row%0d negedge", r), neg, tbl[r].neg);
      check($sformatf("row%0d pending", r), pend, tbl[r].pnd);
      check($sformatf("row%0d overflow", r), ovf, tbl[r].ovf);
      check($sformatf("row%0d irq", r), irq, |tbl[r].pnd);
      check_hi($sformatf("row%0d", r));
    end

    // Mode 00 on ch0: the fall still strobes but captures nothing.
    @(negedge clk);
    mode = 8'b11_10_11_00; d = 4'b1000; clear = '0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    check("mode00 level", level, 4'b1000);
    check("mode00 negedge", neg, 4'b0001);
    @(posedge clk); #1;
    check("mode00 pending", pend, 0);
    check("mode00 irq", irq, 0);

    // Reset mid-filter on ch1 rise: immediate clear, no strobe afterwards.
    @(negedge clk); d = 4'b1010;
    repeat (3) @(posedge clk);
    #2 arst_ni = 1'b0;
    #1;
    check("midrst level", level, 0);
    check("midrst posedge", pos, 0);
    check("midrst pending", pend, 0);
    check("midrst irq", irq, 0);
    check("midrst hi level", level1, 1);
    d = 4'b0000;
    @(negedge clk); arst_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-rst%0d level", k), level, 0);
      check($sformatf("post-rst%0d posedge", k), pos, 0);
      check($sformatf("post-rst%0d pending", k), pend, 0);
      check_hi($sformatf("post-rst%0d", k));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
